// File: rtl/dac_poll_spi.sv
// dac_poll_spi: round-robin multi-channel DAC refresh over SPI, clk_core domain.
// Ports: clk_core, rst_n (async low), en, data_in[N_CH*DW] -> sclk, dout, sync_n,
//   pos, busy, frame_done. Option macro DAC_POLL_DIRTY_EN adds skip-unchanged SCAN.
module dac_poll_spi #(
  parameter int N_CH    = 8,
  parameter int DW      = 12,
  parameter int FRAME_W = 16,
  parameter int CLK_DIV = 14,
  parameter int GAP_CYC = 40,
  localparam int ADDR_W = $clog2(N_CH)
) (
  input  logic                 clk_core,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N_CH*DW-1:0]   data_in,
  output logic                 sclk,
  output logic                 dout,
  output logic                 sync_n,
  output logic [ADDR_W-1:0]    pos,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int BW  = $clog2(FRAME_W + 1);
  localparam int DVW = $clog2(CLK_DIV + 1);
  localparam int GW  = $clog2(GAP_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_CH - 1);

`ifdef DAC_POLL_DIRTY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_GAP, S_SCAN
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_GAP
  } state_t;
`endif

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ch_ptr;
  logic [FRAME_W-1:0]  r_shift;
  logic [BW-1:0]       r_bits;
  logic [DVW-1:0]      r_div;
  logic [GW-1:0]       r_gap;
  logic                r_sclk;
  logic                r_dout;
  logic                r_sync_n;
  logic [ADDR_W-1:0]   r_pos;
  logic                r_done;

  logic [DW-1:0]       w_sel;
  logic [FRAME_W-1:0]  w_frame;
  logic [ADDR_W-1:0]   w_next_ptr;
  logic                w_last;
  state_t              w_start;

  assign w_sel      = data_in[r_ch_ptr*DW +: DW];
  assign w_frame    = FRAME_W'({r_ch_ptr, w_sel});
  assign w_next_ptr = (r_ch_ptr == LAST) ? '0 : r_ch_ptr + 1'b1;

  // end of the low phase of the final bit
  assign w_last = (r_state == S_SHIFT) && (r_div == '0)
                  && !r_sclk && (r_bits == BW'(1));

`ifdef DAC_POLL_DIRTY_EN
  logic [DW-1:0]       r_data;
  logic [DW-1:0]       r_shadow [N_CH];
  logic [N_CH-1:0]     r_valid;
  logic                w_clean;

  assign w_clean = r_valid[r_ch_ptr] && (w_sel == r_shadow[r_ch_ptr]);
  assign w_start = S_SCAN;

  // shadow holds what the DAC actually received
  always_ff @(posedge clk_core) begin
    if (w_last) r_shadow[r_ch_ptr] <= r_data;
  end

  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= '0;
    end else begin
      if (r_state == S_LOAD) r_data <= w_sel;
      if (w_last) r_valid[r_ch_ptr] <= 1'b1;
    end
  end
`else
  assign w_start = S_LOAD;
`endif

  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ch_ptr <= '0;
      r_shift  <= '0;
      r_bits   <= '0;
      r_div    <= '0;
      r_gap    <= '0;
      r_sclk   <= 1'b1;
      r_dout   <= 1'b0;
      r_sync_n <= 1'b1;
      r_pos    <= LAST;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (en) r_state <= w_start;
        end
`ifdef DAC_POLL_DIRTY_EN
        S_SCAN: begin
          if (!w_clean) r_state <= S_LOAD;
          else if (!en) r_state <= S_IDLE;
          else r_ch_ptr <= w_next_ptr;
        end
`endif
        S_LOAD: begin
          r_shift  <= w_frame << 1;
          r_dout   <= w_frame[FRAME_W-1];
          r_sclk   <= 1'b1;
          r_sync_n <= 1'b0;
          r_bits   <= BW'(FRAME_W);
          r_div    <= DVW'(CLK_DIV - 1);
          r_state  <= S_SHIFT;
        end
        S_SHIFT: begin
          if (r_div != '0) begin
            r_div <= r_div - 1'b1;
          end else begin
            r_div <= DVW'(CLK_DIV - 1);
            if (r_sclk) begin
              r_sclk <= 1'b0;
            end else if (w_last) begin
              r_sclk   <= 1'b1;
              r_sync_n <= 1'b1;
              r_dout   <= 1'b0;
              r_pos    <= r_ch_ptr;
              r_done   <= 1'b1;
              r_ch_ptr <= w_next_ptr;
              r_gap    <= GW'(GAP_CYC - 1);
              r_state  <= S_GAP;
            end else begin
              r_bits  <= r_bits - 1'b1;
              r_sclk  <= 1'b1;
              r_dout  <= r_shift[FRAME_W-1];
              r_shift <= r_shift << 1;
            end
          end
        end
        S_GAP: begin
          if (r_gap != '0) r_gap <= r_gap - 1'b1;
          else if (en) r_state <= w_start;
          else r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sclk       = r_sclk;
  assign dout       = r_dout;
  assign sync_n     = r_sync_n;
  assign pos        = r_pos;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_done;

endmodule

// File: tb/tb_dac_poll_spi.sv
// tb_dac_poll_spi: scoreboard bench for dac_poll_spi (default build).
// Captures SPI frames from the pins and checks them against queued expectations.
module tb_dac_poll_spi;

  logic        clk_core = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [47:0] data_in = '0;
  logic        sclk, dout, sync_n, busy, frame_done;
  logic [1:0]  pos;

  dac_poll_spi #(
    .N_CH(4), .DW(12), .FRAME_W(16), .CLK_DIV(2), .GAP_CYC(4)
  ) dut (
    .clk_core(clk_core), .rst_n(rst_n), .en(en), .data_in(data_in),
    .sclk(sclk), .dout(dout), .sync_n(sync_n), .pos(pos),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk_core = ~clk_core;

  typedef struct {
    logic [15:0] frame;
    logic [1:0]  pos;
    int          per;
  } exp_t;

  exp_t   q[$];
  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;

  always @(posedge clk_core) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: deserialise on sclk falling edges, compare at frame_done
  logic [15:0] cap = '0;
  int          nbits = 0;
  int          lowcnt = 0;
  logic        prev_sclk = 1'b1;
  longint      last_done = 0;
  exp_t        e;

  always @(negedge clk_core) begin
    if (frame_done) begin
      chk("frame_expected", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("frame", 32'(cap), 32'(e.frame));
        chk("bits", 32'(nbits), 16);
        chk("sync_low", 32'(lowcnt), 64);
        chk("pos", 32'(pos), 32'(e.pos));
        if (e.per != 0) chk("period", 32'(cyc - last_done), 32'(e.per));
      end
      last_done = cyc;
      nbits = 0;
      lowcnt = 0;
    end else if (!sync_n) begin
      lowcnt++;
      if (prev_sclk && !sclk) begin
        cap = {cap[14:0], dout};
        nbits++;
      end
    end else begin
      nbits = 0;
      lowcnt = 0;
    end
    prev_sclk = sclk;
  end

  task automatic cycles(int n);
    repeat (n) @(posedge clk_core);
    #1;
  endtask

  task automatic wait_done(int limit, string nm);
    for (int k = 0; k < limit; k++) begin
      @(negedge clk_core);
      if (frame_done) break;
    end
    chk({"done_", nm}, 32'(frame_done), 1);
  endtask

  task automatic push(logic [15:0] f, logic [1:0] p, int per);
    exp_t x;
    x.frame = f;
    x.pos = p;
    x.per = per;
    q.push_back(x);
  endtask

  logic any_low;

  initial begin
    // reset and idle
    cycles(3);
    chk("rst_out", {25'd0, sclk, sync_n, dout, busy, frame_done, pos},
        32'b1100011);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_core);
      chk("idle_out", {25'd0, sclk, sync_n, dout, busy, frame_done, pos},
          32'b1100011);
    end

    // single frame from a one-cycle en pulse
    data_in[11:0] = 12'hABC;
    push(16'h0ABC, 2'd0, 0);
    cycles(1);
    en = 1'b1;
    cycles(1);
    en = 1'b0;
    wait_done(300, "single");
    repeat (3) @(negedge clk_core);
    chk("gap_busy", 32'(busy), 1);
    @(negedge clk_core);
    chk("idle_after_gap", 32'(busy), 0);
    any_low = 1'b0;
    repeat (100) begin
      @(negedge clk_core);
      if (!sync_n) any_low = 1'b1;
    end
    chk("no_extra_frame", 32'(any_low), 0);

    // continuous polling, channel 1 changed mid-shift
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    data_in = {12'hFFF, 12'hABC, 12'h222, 12'h111};
    push(16'h0111, 2'd0, 0);
    push(16'h1222, 2'd1, 69);
    push(16'h2ABC, 2'd2, 69);
    push(16'h3FFF, 2'd3, 69);
    push(16'h0111, 2'd0, 69);
    push(16'h1222, 2'd1, 69);
    push(16'h2ABC, 2'd2, 69);
    push(16'h3FFF, 2'd3, 69);
    push(16'h0111, 2'd0, 69);
    push(16'h1333, 2'd1, 69);
    cycles(1);
    en = 1'b1;
    for (int i = 0; i < 5; i++) wait_done(300, "cont");
    cycles(25);
    chk("mid_shift", 32'(sync_n), 0);
    data_in[23:12] = 12'h333;
    for (int i = 0; i < 4; i++) wait_done(300, "cont2");
    cycles(10);
    en = 1'b0;
    wait_done(300, "last");
    repeat (20) @(negedge clk_core);
    chk("cont_idle", 32'(busy), 0);

    // async reset in the middle of a frame
    data_in[11:0] = 12'h5A5;
    cycles(1);
    en = 1'b1;
    cycles(32);
    chk("pre_rst_low", 32'(sync_n), 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {25'd0, sclk, sync_n, dout, busy, frame_done, pos},
        32'b1100011);
    push(16'h05A5, 2'd0, 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(5);
    en = 1'b0;
    wait_done(300, "post_rst");
    repeat (20) @(negedge clk_core);
    chk("final_idle", 32'(busy), 0);
    chk("queue_empty", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
